// File: rtl/fpu_pkg.sv
// Shared types and default widths for the parametrised add/sub FPU.
package fpu_pkg;

    localparam int DEF_EXP_W = 6;
    localparam int DEF_MAN_W = 25;

    typedef enum logic [3:0] {
        EXACT     = 4'b0001,
        INEXACT   = 4'b0010,
        OVERFLOW  = 4'b0100,
        UNDERFLOW = 4'b1000
    } status_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        OPERATE,
        NORMALIZE,
        ROUND,
        OUTPUT
    } fsm_t;

endpackage

// File: rtl/fpu_rne_round.sv
// Round-to-nearest-even on a mantissa (hidden bit included) with guard/round/sticky bits.
module fpu_rne_round
    import fpu_pkg::*;
#(
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic [MAN_W:0] mant,
    input  logic           guard,
    input  logic           rnd,
    input  logic           sticky,
    output logic [MAN_W:0] rounded,
    output logic           carry,
    output logic           inexact
);

    logic inc;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        inc              = guard & (rnd | sticky | mant[0]);
        inexact          = guard | rnd | sticky;
        {carry, rounded} = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, inc};
    end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle floating-point adder/subtractor: sign | EXP_W exponent | MAN_W fraction, hidden 1,
// RNE rounding, saturation on overflow, signed zero on underflow.
module fpu_addsub_param
    import fpu_pkg::*;
#(
    parameter  int EXP_W = DEF_EXP_W,
    parameter  int MAN_W = DEF_MAN_W,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clock100KHz,
    input  logic         reset,
    input  logic         start_in,
    input  logic         op_sel_in,
    input  logic [W-1:0] op_A_in,
    input  logic [W-1:0] op_B_in,
    output logic         busy_out,
    output logic         done_out,
    output logic [W-1:0] data_out,
    output logic [3:0]   status_out
);

    // Extended mantissa: hidden | fraction | guard | round | sticky.
    localparam int             MW       = MAN_W + 4;
    localparam logic [EXP_W:0] EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE  = 1;
    localparam logic [EXP_W:0] COLLAPSE = (EXP_W + 1)'(MAN_W + 3);

    fsm_t             state;
    logic [W-1:0]     a_q, b_q;
    logic             op_q;
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MW-1:0]    man_a, man_b;
    logic             sign_big, sign_small;
    logic [MW-1:0]    man_big, man_small;
    logic             res_sign;
    logic [EXP_W:0]   res_exp;
    logic [MW:0]      res_man;
    logic             ovf, unf, inexact, zero;

    logic             hid_a, hid_b, a_big;
    logic [EXP_W-1:0] exp_diff;
    logic [MW-1:0]    small_raw, small_shift, lost_mask;
    logic [MW:0]      sum;
    logic [EXP_W:0]   exp_inc, exp_dec;

    always_comb begin
        hid_a       = |a_q[W-2:MAN_W];
        hid_b       = |b_q[W-2:MAN_W];
        a_big       = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));
        small_raw   = a_big ? man_b : man_a;
        exp_diff    = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
        lost_mask   = '0;
        small_shift = '0;
        if ({1'b0, exp_diff} >= COLLAPSE) begin
            small_shift = {{(MW - 1){1'b0}}, |small_raw};
        end else begin
            // Bits shifted past the sticky position are folded into it.
            lost_mask      = ~({MW{1'b1}} << exp_diff);
            small_shift    = small_raw >> exp_diff;
            small_shift[0] = small_shift[0] | (|(small_raw & lost_mask));
        end
        if (sign_big == sign_small) begin
            sum = {1'b0, man_big} + {1'b0, man_small};
        end else begin
            sum = {1'b0, man_big} - {1'b0, man_small};
        end
        exp_inc = res_exp + EXP_ONE;
        exp_dec = res_exp - EXP_ONE;
    end

    logic [MAN_W:0] rnd_man, rnd_norm;
    logic           rnd_carry, rnd_inexact;

    fpu_rne_round #(.MAN_W(MAN_W)) u_round (
        .mant    (res_man[MW-1:3]),
        .guard   (res_man[2]),
        .rnd     (res_man[1]),
        .sticky  (res_man[0]),
        .rounded (rnd_man),
        .carry   (rnd_carry),
        .inexact (rnd_inexact)
    );

    assign rnd_norm = rnd_carry ? {1'b1, rnd_man[MAN_W:1]} : rnd_man;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            // NOTE: datapath registers are reset too, so an aborted operation leaves no stale result behind.
            state      <= IDLE;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            exp_a      <= '0;
            exp_b      <= '0;
            man_a      <= '0;
            man_b      <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            man_big    <= '0;
            man_small  <= '0;
            res_sign   <= 1'b0;
            res_exp    <= '0;
            res_man    <= '0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            inexact    <= 1'b0;
            zero       <= 1'b0;
        end else begin
            done_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_in) begin
                        a_q      <= op_A_in;
                        b_q      <= op_B_in;
                        op_q     <= op_sel_in;
                        busy_out <= 1'b1;
                        ovf      <= 1'b0;
                        unf      <= 1'b0;
                        inexact  <= 1'b0;
                        zero     <= 1'b0;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_a <= a_q[W-1];
                    sign_b <= b_q[W-1] ^ op_q;
                    exp_a  <= a_q[W-2:MAN_W];
                    exp_b  <= b_q[W-2:MAN_W];
                    man_a  <= {hid_a, a_q[MAN_W-1:0] & {MAN_W{hid_a}}, 3'b000};
                    man_b  <= {hid_b, b_q[MAN_W-1:0] & {MAN_W{hid_b}}, 3'b000};
                    state  <= ALIGN;
                end
                ALIGN: begin
                    sign_big   <= a_big ? sign_a : sign_b;
                    sign_small <= a_big ? sign_b : sign_a;
                    man_big    <= a_big ? man_a : man_b;
                    man_small  <= small_shift;
                    res_exp    <= {1'b0, (a_big ? exp_a : exp_b)};
                    state      <= OPERATE;
                end
                OPERATE: begin
                    res_man  <= sum;
                    res_sign <= sign_big;
                    state    <= NORMALIZE;
                end
                NORMALIZE: begin
                    if (res_man == '0) begin
                        zero  <= 1'b1;
                        state <= OUTPUT;
                    end else if (res_man[MW]) begin
                        if (exp_inc > EXP_MAX) begin
                            ovf   <= 1'b1;
                            state <= OUTPUT;
                        end else begin
                            // A carry shift always leaves the hidden bit set, so rounding can follow directly.
                            res_man <= {1'b0, res_man[MW:2], res_man[1] | res_man[0]};
                            res_exp <= exp_inc;
                            state   <= ROUND;
                        end
                    end else if (!res_man[MW-1]) begin
                        if (exp_dec < EXP_ONE) begin
                            unf   <= 1'b1;
                            state <= OUTPUT;
                        end else begin
                            res_man <= res_man << 1;
                            res_exp <= exp_dec;
                        end
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    inexact <= rnd_inexact;
                    if (rnd_carry && (exp_inc > EXP_MAX)) begin
                        ovf <= 1'b1;
                    end else begin
                        res_man <= {1'b0, rnd_norm, 3'b000};
                        if (rnd_carry) begin
                            res_exp <= exp_inc;
                        end
                    end
                    state <= OUTPUT;
                end
                OUTPUT: begin
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                    if (ovf) begin
                        data_out   <= {res_sign, {(W - 1){1'b1}}};
                        status_out <= OVERFLOW;
                    end else if (unf) begin
                        data_out   <= {res_sign, {(W - 1){1'b0}}};
                        status_out <= UNDERFLOW;
                    end else if (zero) begin
                        data_out   <= '0;
                        status_out <= EXACT;
                    end else begin
                        data_out   <= {res_sign, res_exp[EXP_W-1:0], res_man[MW-2:3]};
                        status_out <= inexact ? INEXACT : EXACT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
